// File: rtl/sine_cap_pkg.sv
// sine_cap_pkg: capture FSM state encoding plus default widths, depth and trigger level
package sine_cap_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam int DATA_W_DEF = 11;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH = 2 ** ADDR_W_DEF;
  localparam logic [DATA_W_DEF-1:0] TRIG_LEVEL_DEF = 11'd1024;
endpackage

// File: rtl/sine_capture_writer_if.sv
// sine_capture_writer_if: control, sample stream and BRAM port A bundle of the capture writer
interface sine_cap_if
  import sine_cap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              arm;
  logic              abort;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              mem_ena;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [DATA_W-1:0] mem_dina;
  logic              busy;
  logic              done;
  modport master (
    output arm, abort, sample_valid, sample_data,
    input  mem_ena, mem_wea, mem_addra, mem_dina, busy, done
  );
  modport slave (
    input  arm, abort, sample_valid, sample_data,
    output mem_ena, mem_wea, mem_addra, mem_dina, busy, done
  );
endinterface

// File: rtl/capture_trigger_det.sv
// capture_trigger_det: rising-crossing detector between two consecutive valid samples
module capture_trigger_det #(
  parameter int                DATA_W     = 11,
  parameter logic [DATA_W-1:0] TRIG_LEVEL = 11'd1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_trig
);
  logic [DATA_W-1:0] r_prev;
  logic              r_have;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_have <= 1'b0;
    end else if (i_clear) begin
      r_have <= 1'b0;
    end else if (i_valid) begin
      r_prev <= i_data;
      r_have <= 1'b1;
    end
  end
  // the first sample after arming has no predecessor and only seeds r_prev
  assign o_trig = i_valid && r_have && (r_prev < TRIG_LEVEL) && (i_data >= TRIG_LEVEL);
endmodule

// File: rtl/sine_capture_writer.sv
// sine_capture_writer: arm -> (trigger) -> write 2**ADDR_W samples into BRAM port A -> done
// RISING_TRIGGER_EN: ARMED waits for a rising crossing of TRIG_LEVEL instead of one cycle.
module sine_capture_writer
  import sine_cap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
`ifdef RISING_TRIGGER_EN
  , parameter logic [DATA_W-1:0] TRIG_LEVEL = TRIG_LEVEL_DEF
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  sine_cap_if.slave bus
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dina;
  logic              r_wr;
  logic              r_busy;
  logic              r_done;
  logic              w_start;
  logic              w_acc;
`ifdef RISING_TRIGGER_EN
  localparam bit TRIG_MODE = 1'b1;
  logic w_trig;
  capture_trigger_det #(.DATA_W(DATA_W), .TRIG_LEVEL(TRIG_LEVEL)) u_trig (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (r_state != ARMED),
    .i_valid (bus.sample_valid),
    .i_data  (bus.sample_data),
    .o_trig  (w_trig)
  );
  assign w_start = (r_state == ARMED) && w_trig;
`else
  localparam bit TRIG_MODE = 1'b0;
  assign w_start = 1'b0;
`endif
  // the triggering sample itself is the first one stored
  assign w_acc = !bus.abort && bus.sample_valid && ((r_state == CAPTURE) || w_start);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_addra <= '0;
      r_dina  <= '0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wr    <= w_acc;
      r_addra <= w_acc ? r_addr : '0;
      r_dina  <= w_acc ? bus.sample_data : '0;
      if (bus.abort) begin
        r_state <= IDLE;
        r_addr  <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        if (w_acc) r_addr <= r_addr + 1'b1;
        case (r_state)
          IDLE, DONE: if (bus.arm) begin
            r_state <= ARMED;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
          ARMED: if (w_start || !TRIG_MODE) r_state <= CAPTURE;
          CAPTURE: if (w_acc && &r_addr) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign bus.mem_ena   = r_wr;
  assign bus.mem_wea   = r_wr;
  assign bus.mem_addra = r_addra;
  assign bus.mem_dina  = r_dina;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_sine_capture_writer.sv
// tb_sine_capture_writer: directed checks of reset, capture, gaps, abort, re-arm and trigger
module tb_sine_capture_writer;
  import sine_cap_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  sine_cap_if #(.DATA_W(DATA_W_DEF), .ADDR_W(ADDR_W_DEF)) bus ();
  sine_capture_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef RISING_TRIGGER_EN
  localparam logic [10:0] OFS = 11'd1024;
  localparam logic [10:0] SEED = 11'd0;
`else
  localparam logic [10:0] OFS = 11'd0;
  localparam logic [10:0] SEED = 11'd77;
`endif
  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [10:0] d);
    bus.sample_valid = v;
    bus.sample_data  = d;
  endtask
  function automatic logic [31:0] got();
    return {11'b0, bus.mem_ena, bus.mem_wea, bus.mem_addra, bus.mem_dina};
  endfunction
  function automatic logic [31:0] nw();
    return {19'b0, bus.mem_ena, bus.mem_wea, bus.mem_dina};
  endfunction
  function automatic logic [31:0] wr(input logic [7:0] a, input logic [10:0] d);
    return {11'b0, 1'b1, 1'b1, a, d};
  endfunction
  function automatic logic [31:0] all_out();
    return {11'b0, bus.busy, bus.done, bus.mem_ena, bus.mem_wea, bus.mem_addra, bus.mem_dina};
  endfunction
  task automatic arm_pulse();
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask
  task automatic do_abort();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
  endtask
  task automatic begin_capture();
    arm_pulse();
    chk("armed_busy", bus.busy, 1);
    drive(1'b1, SEED);
    step();
    chk("armed_nowr", nw(), 0);
    drive(1'b0, 11'd0);
  endtask
  task automatic feed(input int n, input int a0, input logic [10:0] d0);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 11'(d0 + 11'(i)));
      step();
      chk("wr", got(), wr(8'(a0 + i), 11'(d0 + 11'(i))));
    end
    drive(1'b0, 11'd0);
  endtask
  initial begin
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    drive(1'b0, 11'd0);
    #12;
    chk("rst_out", all_out(), 0);
    rst_n = 1'b1;
    step();
    chk("idle_out", all_out(), 0);
    begin_capture();
    feed(37, 0, OFS);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", all_out(), 0);
    step();
    step();
    rst_n = 1'b1;
    drive(1'b1, OFS + 11'd5);
    step();
    chk("post_rst_nowr", nw(), 0);
    chk("post_rst_busy", bus.busy, 0);
    step();
    chk("post_rst_nowr2", nw(), 0);
    drive(1'b0, 11'd0);
    begin_capture();
    for (int i = 0; i < 256; i++) begin
      bus.arm = (i == 128);
      drive(1'b1, 11'(OFS + 11'(i)));
      step();
      chk("cap", got(), wr(8'(i), 11'(OFS + 11'(i))));
      if (i == 128) chk("arm_in_cap_busy", bus.busy, 1);
      if (i == 254) chk("done_early", bus.done, 0);
      if (i == 255) begin
        chk("done_last", bus.done, 1);
        chk("busy_last", bus.busy, 0);
      end
    end
    bus.arm = 1'b0;
    drive(1'b1, OFS + 11'd256);
    step();
    chk("no_257th", nw(), 0);
    chk("done_hold", bus.done, 1);
    drive(1'b0, 11'd0);
    begin_capture();
    chk("rearm_done", bus.done, 0);
    feed(3, 0, OFS + 11'd40);
    do_abort();
    begin_capture();
    drive(1'b1, OFS + 11'd500);
    step();
    chk("gap_w0", got(), wr(8'd0, OFS + 11'd500));
    drive(1'b0, OFS + 11'd501);
    step();
    chk("gap_n1", nw(), 0);
    drive(1'b0, OFS + 11'd502);
    step();
    chk("gap_n2", nw(), 0);
    drive(1'b1, OFS + 11'd503);
    step();
    chk("gap_w1", got(), wr(8'd1, OFS + 11'd503));
    drive(1'b0, 11'd0);
    do_abort();
    begin_capture();
    feed(100, 0, OFS);
    drive(1'b1, OFS + 11'd100);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_nowr", nw(), 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    step();
    chk("abort_idle_nowr", nw(), 0);
    drive(1'b0, 11'd0);
    begin_capture();
    feed(1, 0, OFS + 11'd9);
    do_abort();
`ifdef RISING_TRIGGER_EN
    arm_pulse();
    drive(1'b1, 11'd1000); step(); chk("trg_1000", nw(), 0);
    drive(1'b1, 11'd1020); step(); chk("trg_1020", nw(), 0);
    drive(1'b1, 11'd1030); step(); chk("trg_1030", got(), wr(8'd0, 11'd1030));
    drive(1'b1, 11'd1040); step(); chk("trg_1040", got(), wr(8'd1, 11'd1040));
    drive(1'b0, 11'd0);
    do_abort();
    arm_pulse();
    drive(1'b1, 11'd1030); step(); chk("notrg_1030", nw(), 0);
    drive(1'b1, 11'd1040); step(); chk("notrg_1040", nw(), 0);
    drive(1'b1, 11'd1000); step(); chk("notrg_1000", nw(), 0);
    drive(1'b1, 11'd1100); step(); chk("trg_1100", got(), wr(8'd0, 11'd1100));
    drive(1'b0, 11'd0);
    do_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
